// File: rtl/disp_sched_pkg.sv
// disp_sched_pkg
//   Shared definitions for the stereo SAD datapath: the disparity scheduler
//   FSM state encoding and the default datapath sizing constants, which the
//   window mux and adder tree also use so all three stay in step.
package disp_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StOutput
    } sched_state_e;

    localparam int unsigned DEFAULT_MAX_DISP     = 16;
    localparam int unsigned DEFAULT_SUM_BITS     = 11;
    localparam int unsigned DEFAULT_TREE_LATENCY = 3;

endpackage

// File: rtl/disp_tag_delay.sv
// disp_tag_delay
//   Fixed-depth shift register that carries the {valid, disp} tag of each
//   tree issue alongside the adder tree, so the tag leaves the last stage in
//   the same cycle the matching window sum arrives.
// Ports:
//   clock    rising-edge clock
//   clear    synchronous clear of every stage
//   data_in  tag entering stage 0
//   data_out tag leaving the last stage
module disp_tag_delay
    import disp_sched_pkg::*;
#(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = DEFAULT_TREE_LATENCY
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clock) begin
        if (clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= data_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign data_out = stage_q[DEPTH-1];

endmodule

// File: rtl/disparity_scheduler.sv
// disparity_scheduler
//   Sweeps disparities 0..MAX_DISP-1 into the SAD adder tree for each accepted
//   pixel, tracks the tree latency with a tag delay line, and keeps the
//   minimum returning sum (lowest disparity wins ties). The winner is offered
//   downstream over valid/ready.
//   Optional feature macro: DISP_SCHED_TIE_EN adds the out_tie output.
// Ports:
//   clock, reset          clock; synchronous active-high reset
//   pix_valid, pix_ready  pixel handshake (ready only in idle)
//   disp_sel, tree_issue  disparity driven into the tree this cycle
//   sad_in                tree sum, TREE_LATENCY cycles after its issue
//   best_disp, best_sad   winning disparity and its SAD
//   out_valid, out_ready  result handshake
//   out_tie               another disparity matched the best SAD (macro only)
module disparity_scheduler
    import disp_sched_pkg::*;
#(
    parameter int unsigned MAX_DISP     = DEFAULT_MAX_DISP,
    parameter int unsigned DISP_BITS    = $clog2(MAX_DISP),
    parameter int unsigned SUM_BITS     = DEFAULT_SUM_BITS,
    parameter int unsigned TREE_LATENCY = DEFAULT_TREE_LATENCY
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    output logic [DISP_BITS-1:0] disp_sel,
    output logic                 tree_issue,
    input  logic [SUM_BITS-1:0]  sad_in,
    output logic [DISP_BITS-1:0] best_disp,
    output logic [SUM_BITS-1:0]  best_sad,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef DISP_SCHED_TIE_EN
    ,
    output logic                 out_tie
`endif
);

    localparam logic [DISP_BITS-1:0] LAST_DISP = DISP_BITS'(MAX_DISP - 1);

    sched_state_e         state_q;
    logic                 first_q;
    logic [DISP_BITS:0]   tag_in;
    logic [DISP_BITS:0]   tag_out;
    logic                 tag_valid;
    logic [DISP_BITS-1:0] tag_disp;

    assign tag_in    = {tree_issue, disp_sel};
    assign tag_valid = tag_out[DISP_BITS];
    assign tag_disp  = tag_out[DISP_BITS-1:0];
    assign pix_ready = (state_q == StIdle);

    // Clearing on reset drops any sums still in flight in the tree.
    disp_tag_delay #(
        .WIDTH (DISP_BITS + 1),
        .DEPTH (TREE_LATENCY)
    ) u_tag_delay (
        .clock    (clock),
        .clear    (reset),
        .data_in  (tag_in),
        .data_out (tag_out)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            first_q    <= 1'b0;
            disp_sel   <= '0;
            tree_issue <= 1'b0;
            best_disp  <= '0;
            best_sad   <= '0;
            out_valid  <= 1'b0;
`ifdef DISP_SCHED_TIE_EN
            out_tie    <= 1'b0;
`endif
        end else begin
            // Winner-take-all on every returning sum; strict compare keeps
            // the lower disparity on a tie since disparities return in order.
            if (tag_valid) begin
                first_q <= 1'b0;
                if (first_q || (sad_in < best_sad)) begin
                    best_sad  <= sad_in;
                    best_disp <= tag_disp;
`ifdef DISP_SCHED_TIE_EN
                    out_tie   <= 1'b0;
`endif
                end
`ifdef DISP_SCHED_TIE_EN
                else if (sad_in == best_sad) begin
                    out_tie <= 1'b1;
                end
`endif
            end

            unique case (state_q)
                StIdle: begin
                    if (pix_valid) begin
                        state_q    <= StIssue;
                        disp_sel   <= '0;
                        tree_issue <= 1'b1;
                        first_q    <= 1'b1;
`ifdef DISP_SCHED_TIE_EN
                        out_tie    <= 1'b0;
`endif
                    end
                end
                StIssue: begin
                    // The tree has no flow control, so issue never stalls.
                    if (disp_sel == LAST_DISP) begin
                        state_q    <= StDrain;
                        disp_sel   <= '0;
                        tree_issue <= 1'b0;
                    end else begin
                        disp_sel <= disp_sel + 1'b1;
                    end
                end
                StDrain: begin
                    if (tag_valid && (tag_disp == LAST_DISP)) begin
                        state_q   <= StOutput;
                        out_valid <= 1'b1;
                    end
                end
                StOutput: begin
                    if (out_ready) begin
                        state_q   <= StIdle;
                        out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disparity_scheduler.sv
module tb_disparity_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [3:0]  disp_sel;
    logic        tree_issue;
    logic [10:0] sad_in;
    logic [3:0]  best_disp;
    logic [10:0] best_sad;
    logic        out_valid;
    logic        out_ready = 1'b0;
`ifdef DISP_SCHED_TIE_EN
    logic        out_tie;
`endif

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Environment model of the adder tree: a sum appears 3 cycles after issue.
    logic [10:0] sad_table [16];
    logic [4:0]  tree_pipe [3];
    logic        garbage = 1'b0;
    logic [10:0] garbage_val = '0;

    disparity_scheduler u_dut (
        .clock      (clock),
        .reset      (reset),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .disp_sel   (disp_sel),
        .tree_issue (tree_issue),
        .sad_in     (sad_in),
        .best_disp  (best_disp),
        .best_sad   (best_sad),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef DISP_SCHED_TIE_EN
        ,
        .out_tie    (out_tie)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc          <= cyc + 1;
        tree_pipe[0] <= {tree_issue, disp_sel};
        tree_pipe[1] <= tree_pipe[0];
        tree_pipe[2] <= tree_pipe[1];
        garbage_val  <= 11'($urandom);
    end

    always_comb begin
        if (garbage) sad_in = garbage_val;
        else if (tree_pipe[2][4] === 1'b1) sad_in = sad_table[tree_pipe[2][3:0]];
        else sad_in = '0;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Pulse pix_valid in the current (idle) cycle; t0 is the accept cycle.
    task automatic send_pixel(output int t0);
        pix_valid = 1'b1;
        t0 = cyc;
        step();
        pix_valid = 1'b0;
    endtask

    task automatic wait_out_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        vectors++;
        if ({disp_sel, tree_issue, best_disp, best_sad, out_valid} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h exp 0",
                     {disp_sel, tree_issue, best_disp, best_sad, out_valid});
        end
`ifdef DISP_SCHED_TIE_EN
        vectors++;
        if (out_tie !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tie got %b exp 0", out_tie);
        end
`endif
        reset = 1'b0;
        step();
        vectors++;
        if (pix_ready !== 1'b1 || tree_issue !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready got ready=%b issue=%b exp 1 0", pix_ready, tree_issue);
        end
    endtask

    task automatic test_descending();
        int t0;
        bit ok;
        for (int d = 0; d < 16; d++) sad_table[d] = 11'(200 - 10 * d);
        out_ready = 1'b0;
        send_pixel(t0);
        for (int k = 0; k < 16; k++) begin
            vectors++;
            if (tree_issue !== 1'b1 || disp_sel !== 4'(k)) begin
                miscompares++;
                $display("FAIL desc_sweep cycle T%0d got issue=%b disp=%0d exp 1 %0d",
                         k + 1, tree_issue, disp_sel, k);
            end
            step();
        end
        vectors++;
        if (tree_issue !== 1'b0 || pix_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL desc_drain got issue=%b ready=%b exp 0 0", tree_issue, pix_ready);
        end
        wait_out_valid(ok);
        vectors++;
        if (!ok || cyc !== t0 + 20) begin
            miscompares++;
            $display("FAIL desc_latency got ok=%b cycle=T%0d exp T20", ok, cyc - t0);
        end
        vectors++;
        if (best_disp !== 4'd15 || best_sad !== 11'd50) begin
            miscompares++;
            $display("FAIL desc_result got %0d/%0d exp 15/50", best_disp, best_sad);
        end
`ifdef DISP_SCHED_TIE_EN
        vectors++;
        if (out_tie !== 1'b0) begin
            miscompares++;
            $display("FAIL desc_tie got %b exp 0", out_tie);
        end
`endif
        out_ready = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b0 || pix_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL desc_handshake got valid=%b ready=%b exp 0 1", out_valid, pix_ready);
        end
    endtask

    task automatic test_tie();
        int t0;
        bit ok;
        for (int d = 0; d < 16; d++) sad_table[d] = 11'd300;
        sad_table[3] = 11'd40;
        sad_table[9] = 11'd40;
        out_ready = 1'b0;
        send_pixel(t0);
        wait_out_valid(ok);
        vectors++;
        if (!ok || best_disp !== 4'd3 || best_sad !== 11'd40) begin
            miscompares++;
            $display("FAIL tie_result got ok=%b %0d/%0d exp 3/40", ok, best_disp, best_sad);
        end
`ifdef DISP_SCHED_TIE_EN
        vectors++;
        if (out_tie !== 1'b1) begin
            miscompares++;
            $display("FAIL tie_flag got %b exp 1", out_tie);
        end
`endif
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_backpressure();
        int t0;
        bit ok;
        for (int d = 0; d < 16; d++) sad_table[d] = 11'(100 + d);
        sad_table[6] = 11'd5;
        out_ready = 1'b0;
        send_pixel(t0);
        wait_out_valid(ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL bp_timeout got no out_valid exp out_valid");
        end
        pix_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || best_disp !== 4'd6 || best_sad !== 11'd5
                || pix_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold %0d got v=%b %0d/%0d rdy=%b exp 1 6/5 0",
                         i, out_valid, best_disp, best_sad, pix_ready);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        vectors++;
        if (out_valid !== 1'b0 || pix_ready !== 1'b1 || tree_issue !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release got v=%b rdy=%b issue=%b exp 0 1 0",
                     out_valid, pix_ready, tree_issue);
        end
        step();
        pix_valid = 1'b0;
        vectors++;
        if (tree_issue !== 1'b1 || disp_sel !== 4'd0 || pix_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_accept got issue=%b disp=%0d rdy=%b exp 1 0 0",
                     tree_issue, disp_sel, pix_ready);
        end
        wait_out_valid(ok);
        vectors++;
        if (!ok || best_disp !== 4'd6 || best_sad !== 11'd5) begin
            miscompares++;
            $display("FAIL bp_second got ok=%b %0d/%0d exp 6/5", ok, best_disp, best_sad);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int t0;
        bit ok;
        for (int d = 0; d < 16; d++) sad_table[d] = 11'(200 + d);
        sad_table[11] = 11'd7;
        out_ready = 1'b1;
        send_pixel(t0);
        for (int i = 0; i < 7; i++) step();
        vectors++;
        if (tree_issue !== 1'b1 || disp_sel !== 4'd7) begin
            miscompares++;
            $display("FAIL mid_pre got issue=%b disp=%0d exp 1 7", tree_issue, disp_sel);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if (tree_issue !== 1'b0 || pix_ready !== 1'b1 || disp_sel !== 4'd0
            || out_valid !== 1'b0 || best_sad !== 11'd0) begin
            miscompares++;
            $display("FAIL mid_reset got issue=%b rdy=%b disp=%0d v=%b sad=%0d exp 0 1 0 0 0",
                     tree_issue, pix_ready, disp_sel, out_valid, best_sad);
        end
        garbage = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (out_valid !== 1'b0 || tree_issue !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_garbage %0d got v=%b issue=%b exp 0 0",
                         i, out_valid, tree_issue);
            end
        end
        garbage = 1'b0;
        out_ready = 1'b0;
        send_pixel(t0);
        wait_out_valid(ok);
        vectors++;
        if (!ok || cyc !== t0 + 20 || best_disp !== 4'd11 || best_sad !== 11'd7) begin
            miscompares++;
            $display("FAIL mid_next got ok=%b T%0d %0d/%0d exp T20 11/7",
                     ok, cyc - t0, best_disp, best_sad);
        end
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        int acc [3];
        int n_acc = 0;
        int rises = 0;
        int highs = 0;
        int rise_cyc [3];
        logic prev = 1'b0;
        for (int d = 0; d < 16; d++) sad_table[d] = 11'(200 - 10 * d);
        out_ready = 1'b1;
        pix_valid = 1'b1;
        for (int i = 0; i < 75; i++) begin
            if (pix_ready === 1'b1 && pix_valid && n_acc < 3) begin
                acc[n_acc] = cyc;
                n_acc++;
            end
            if (out_valid === 1'b1) begin
                highs++;
                if (!prev && rises < 3) begin
                    rise_cyc[rises] = cyc;
                    rises++;
                end
            end
            prev = out_valid;
            step();
            if (n_acc == 3) pix_valid = 1'b0;
        end
        vectors++;
        if (n_acc !== 3 || rises !== 3 || highs !== 3) begin
            miscompares++;
            $display("FAIL b2b_counts got acc=%0d pulses=%0d high=%0d exp 3 3 3",
                     n_acc, rises, highs);
        end
        if (n_acc == 3 && rises == 3) begin
            for (int k = 1; k < 3; k++) begin
                vectors++;
                if (acc[k] - acc[k-1] !== 21) begin
                    miscompares++;
                    $display("FAIL b2b_period %0d got %0d exp 21", k, acc[k] - acc[k-1]);
                end
            end
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (rise_cyc[k] - acc[k] !== 20) begin
                    miscompares++;
                    $display("FAIL b2b_latency %0d got %0d exp 20", k, rise_cyc[k] - acc[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_descending();
        test_tie();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/disparity_scheduler.md
# disparity_scheduler

Sequencer and winner-take-all selector for the stereo SAD datapath. For each accepted pixel it sweeps the disparity offset 0..MAX_DISP-1, one per cycle, into the window-mux/adder-tree pipeline and tracks the fixed tree latency with a tag delay line. It compares returning window sums and presents the minimum-SAD disparity to the depth-map writer over a valid/ready handshake.

## Interface
- MAX_DISP, 16: disparities searched per pixel (≥2)
- DISP_BITS, 4: clog2(MAX_DISP)
- SUM_BITS, 11: adder-tree output width
- TREE_LATENCY, 3: cycles from issue to matching sum on sad_in (≥1)

- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- pix_valid  in  1  new pixel window available
- pix_ready  out  1  scheduler idle, will accept pixel
- disp_sel  out  DISP_BITS  disparity offset driving right-image window mux
- tree_issue  out  1  disp_sel valid into tree this cycle
- sad_in  in  SUM_BITS  adder-tree sum, TREE_LATENCY cycles after issue
- best_disp  out  DISP_BITS  winning disparity
- best_sad  out  SUM_BITS  winning SAD
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_tie  out  1  only with DISP_SCHED_TIE_EN

## Operation
- FSM states IDLE, ISSUE, DRAIN, OUTPUT.
- IDLE: pix_ready=1. pix_valid&pix_ready -> ISSUE; disp counter=0, first-flag set.
- ISSUE: tree_issue=1, disp_sel=counter, counter+1 per cycle. Issue with disp_sel=MAX_DISP-1 -> DRAIN. Never stalls; the tree has no flow control.
- Tag delay line: TREE_LATENCY stages of {valid, disp}. Stage 0 loads {tree_issue, disp_sel}; shifts every cycle.
- Compare when tag output valid:
  - first tag of the pixel always loads best_sad/best_disp.
  - later tags replace only if sad_in < best_sad (strict). Ties keep the lower disparity.
- DRAIN: tree_issue=0. When the last tag is consumed -> OUTPUT.
- OUTPUT: out_valid=1, best_* held stable. out_valid&out_ready -> IDLE. pix_ready=0 in all states but IDLE.
- sad_in is ignored whenever the tag output is invalid.
- Reset (any state, including mid-ISSUE/DRAIN):
  - next state IDLE, all tags cleared.
  - disp_sel=0, tree_issue=0, best_disp=0, best_sad=0, out_valid=0, out_tie=0.
  - pix_ready=1 in the first cycle after reset.
  - stale sums still in the tree are discarded.

## Timing
- Accept at cycle T0: issues in T1..T(MAX_DISP). The sum for the issue at Tk is sampled at Tk+TREE_LATENCY.
- out_valid first asserts in T0+MAX_DISP+TREE_LATENCY+1 (T20 at defaults).
- Same-cycle out handshake -> IDLE next cycle. Minimum pixel period MAX_DISP+TREE_LATENCY+2 (21).
- disp_sel, tree_issue, best_*, out_valid and out_tie are registered. pix_ready is decoded from state.

## Configuration
- DISP_SCHED_TIE_EN defined:
  - adds out_tie, set when any later sad_in equals the current best_sad.
  - cleared when a strictly smaller SAD replaces the best.
  - cleared at pixel accept; held through OUTPUT.
- Undefined: no out_tie port and no tie logic; behaviour otherwise identical.

## Structure
- Shared package disp_sched_pkg:
  - state encoding (IDLE, ISSUE, DRAIN, OUTPUT).
  - default MAX_DISP, SUM_BITS, TREE_LATENCY constants, also used by the window mux and adder tree.
- One sub-module: disp_tag_delay, a parameterized {valid, disp} shift register with synchronous clear. Width DISP_BITS+1, depth TREE_LATENCY.

## Test plan
- Reset: assert reset 2 cycles -> all registered outputs 0, pix_ready=1 next cycle, no tree_issue.
- Descending SAD: sad_in=200-10*d -> best_disp=15, best_sad=50, out_valid at T0+20, disp_sel sweeps 0..15 in T1..T16.
- Tie: SAD 40 at d=3 and d=9, 300 elsewhere -> best_disp=3, best_sad=40. With DISP_SCHED_TIE_EN, out_tie=1.
- Backpressure: out_ready=0 for 10 cycles in OUTPUT -> out_valid, best_disp and best_sad stable, pix_ready=0. A pending pix_valid is accepted only the cycle after the handshake.
- Reset mid-ISSUE at disp_sel=7: next cycle IDLE, tree_issue=0. Garbage on sad_in for 5 cycles produces no out_valid. The next pixel yields a correct, independent result.
- Back-to-back: pix_valid and out_ready held 1 for 3 pixels -> accepts 21 cycles apart, three out_valid pulses each 1 cycle wide.
